// File: rtl/param_mux_arbiter_if.sv
// Handshake bundle for param_mux_arbiter: per-channel producer side plus one consumer side.
// With PMUX_STATS_EN defined the bundle also carries the out_count transfer counter.
interface param_mux_arbiter_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
);
   logic [WIDTH*CHANNELS-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;
`ifdef PMUX_STATS_EN
   logic [15:0]               out_count;
`endif

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
`ifdef PMUX_STATS_EN
      , input out_count
`endif
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
`ifdef PMUX_STATS_EN
      , output out_count
`endif
   );
endinterface

// File: rtl/param_mux_arbiter.sv
// N:1 registered selector, fixed-select or round-robin, one output register stage.
// Optional PMUX_STATS_EN adds a saturating 16-bit count of output transfers.
module param_mux_arbiter #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input logic                clk,
   input logic                reset,
   param_mux_arbiter_if.slave bus
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [SEL_W-1:0]    chan_q, chan_d;
   logic                valid_q, valid_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;

   logic                fix_hit, hi_hit, lo_hit;
   logic [SEL_W-1:0]    fix_g, hi_g, lo_g;
   logic                grant_valid;
   logic [SEL_W-1:0]    grant;
   logic                load, take;
   logic [WIDTH-1:0]    grant_data;
   logic [CHANNELS-1:0] in_ready_c;

   // Round-robin scan split in two passes: channels at or above ptr first,
   // otherwise the lowest valid channel below ptr (the wrap-around part).
   always_comb begin
      fix_hit = 1'b0;
      hi_hit  = 1'b0;
      lo_hit  = 1'b0;
      fix_g   = '0;
      hi_g    = '0;
      lo_g    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!fix_hit && (int'(bus.sel) == i) && bus.in_valid[i]) begin
            fix_hit = 1'b1;
            fix_g   = SEL_W'(i);
         end
         if (!hi_hit && (i >= int'(ptr_q)) && bus.in_valid[i]) begin
            hi_hit = 1'b1;
            hi_g   = SEL_W'(i);
         end
         if (!lo_hit && bus.in_valid[i]) begin
            lo_hit = 1'b1;
            lo_g   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      grant_valid = bus.mode ? (hi_hit | lo_hit) : fix_hit;
      grant       = bus.mode ? (hi_hit ? hi_g : lo_g) : fix_g;
      load        = !valid_q | bus.out_ready;
      take        = load & grant_valid & !reset;

      grant_data = '0;
      in_ready_c = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data    = bus.in_data[i*WIDTH +: WIDTH];
            in_ready_c[i] = take;
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (take) begin
         data_d  = grant_data;
         chan_d  = grant;
         valid_d = 1'b1;
         if (bus.mode)
            ptr_d = (grant == SEL_W'(CHANNELS-1)) ? '0 : grant + 1'b1;
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = valid_q;

`ifdef PMUX_STATS_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (valid_q && bus.out_ready && (count_q != 16'hFFFF))
         count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_param_mux_arbiter.sv
// Directed bench for param_mux_arbiter: fixed select, round-robin order, stall, async reset, empty case.
// The saturation run is compiled in only when PMUX_STATS_EN is defined.
module tb_param_mux_arbiter;
   localparam int WIDTH    = 16;
   localparam int CHANNELS = 8;
   localparam int SEL_W    = 3;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   param_mux_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

   param_mux_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [15:0] d, input logic [2:0] c, input logic v);
      chk({tag, " data"},  32'(bus.out_data),  32'(d));
      chk({tag, " chan"},  32'(bus.out_chan),  32'(c));
      chk({tag, " valid"}, 32'(bus.out_valid), 32'(v));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < CHANNELS; i++)
         bus.in_data[i*WIDTH +: WIDTH] = 16'hC000 + 16'(i);
      bus.in_data[5*WIDTH +: WIDTH] = 16'hA5A5;
      bus.in_valid  = 8'hFF;
      bus.mode      = 1'b0;
      bus.sel       = 3'd5;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      #1;
      check_out("reset", 16'h0000, 3'd0, 1'b0);
      chk("reset in_ready", 32'(bus.in_ready), 32'h00);
      tick();
      tick();

      // Fixed mode, sel=5
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("fix5 in_ready", 32'(bus.in_ready), 32'h20);
      tick();
      check_out("fix5", 16'hA5A5, 3'd5, 1'b1);

      // Fixed mode, selected channel not valid
      bus.sel      = 3'd2;
      bus.in_valid = 8'hFB;
      #1;
      chk("fix2 in_ready", 32'(bus.in_ready), 32'h00);
      tick();
      chk("fix2 valid", 32'(bus.out_valid), 32'h0);
      tick();
      chk("fix2 valid hold", 32'(bus.out_valid), 32'h0);

      // Round-robin 0 -> 4 -> 7 -> 0
      bus.mode     = 1'b1;
      bus.in_valid = 8'h91;
      #1;
      chk("rr1 in_ready", 32'(bus.in_ready), 32'h01);
      tick();
      check_out("rr1", 16'hC000, 3'd0, 1'b1);
      chk("rr2 in_ready", 32'(bus.in_ready), 32'h10);
      tick();
      check_out("rr2", 16'hC004, 3'd4, 1'b1);
      chk("rr3 in_ready", 32'(bus.in_ready), 32'h80);
      tick();
      check_out("rr3", 16'hC007, 3'd7, 1'b1);
      chk("rr4 in_ready", 32'(bus.in_ready), 32'h01);
      tick();
      check_out("rr4", 16'hC000, 3'd0, 1'b1);

      // Output stall for 3 cycles, then resume (ptr=1 -> ch4)
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall in_ready", 32'(bus.in_ready), 32'h00);
         tick();
         check_out("stall", 16'hC000, 3'd0, 1'b1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("resume in_ready", 32'(bus.in_ready), 32'h10);
      tick();
      check_out("resume", 16'hC004, 3'd4, 1'b1);

      // Move ptr to 3 via ch2, then hold the word and pulse reset
      bus.in_valid = 8'h04;
      #1;
      chk("ptr3 in_ready", 32'(bus.in_ready), 32'h04);
      tick();
      check_out("ptr3", 16'hC002, 3'd2, 1'b1);
      bus.in_valid  = 8'h00;
      bus.out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_out("async reset", 16'h0000, 3'd0, 1'b0);
      bus.in_valid  = 8'h12;
      bus.out_ready = 1'b1;
      #1;
      chk("reset gate in_ready", 32'(bus.in_ready), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post reset in_ready", 32'(bus.in_ready), 32'h02);
      tick();
      check_out("post reset", 16'hC001, 3'd1, 1'b1);

      // Empty: word drains, ptr holds at 2
      bus.in_valid = 8'h00;
      #1;
      chk("empty in_ready", 32'(bus.in_ready), 32'h00);
      tick();
      chk("empty valid", 32'(bus.out_valid), 32'h0);
      bus.in_valid = 8'h12;
      #1;
      chk("ptr hold in_ready", 32'(bus.in_ready), 32'h10);
      tick();
      check_out("ptr hold", 16'hC004, 3'd4, 1'b1);

      // Mode switch to fixed, back-to-back reload
      bus.mode     = 1'b0;
      bus.sel      = 3'd7;
      bus.in_valid = 8'h80;
      #1;
      chk("b2b in_ready", 32'(bus.in_ready), 32'h80);
      tick();
      check_out("b2b", 16'hC007, 3'd7, 1'b1);

`ifdef PMUX_STATS_EN
      reset = 1'b1;
      #1;
      chk("count reset", 32'(bus.out_count), 32'h0);
      @(negedge clk);
      reset        = 1'b0;
      bus.sel      = 3'd0;
      bus.in_valid = 8'h01;
      tick();
      tick();
      chk("count one", 32'(bus.out_count), 32'h1);
      for (int k = 0; k < 70000; k++)
         @(posedge clk);
      #1;
      chk("count sat", 32'(bus.out_count), 32'hFFFF);
      tick();
      tick();
      chk("count hold", 32'(bus.out_count), 32'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
